// File: rtl/pulse_width_meter.sv
// Measures high time and period of a signal from edge-detector pulses and
// presents each completed measurement as a record on a valid/ready port.
module pulse_width_meter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             clear,
    input  logic             rising_edge,
    input  logic             falling_edge,
    output logic [CNT_W-1:0] high_time,
    output logic [CNT_W-1:0] period,
    output logic             saturated,
    output logic             meas_valid,
    input  logic             meas_ready,
    output logic             overrun,
    output logic [CNT_W-1:0] edge_count,
    output logic [1:0]       state_dbg
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HIGH = 2'd1,
        S_LOW  = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // Output handshake: a record transfers on any cycle with meas_valid && meas_ready;
    // while meas_valid is high and not yet transferred the record fields are held stable.

    state_t           state_q, state_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_hold_q, hi_hold_d;
    logic [CNT_W-1:0] high_time_q, high_time_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             saturated_q, saturated_d;
    logic             meas_valid_q, meas_valid_d;
    logic             overrun_q, overrun_d;
    logic [CNT_W-1:0] edge_count_q, edge_count_d;

    logic rise_ok;
    logic fall_ok;
    logic xfer;
    logic rec_done;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    always_comb begin
        // Simultaneous pulses are a protocol violation and are ignored.
        rise_ok = enable && rising_edge && !falling_edge;
        fall_ok = enable && falling_edge && !rising_edge;
        xfer    = meas_valid_q && meas_ready;

        state_d      = state_q;
        hi_cnt_d     = hi_cnt_q;
        per_cnt_d    = per_cnt_q;
        hi_hold_d    = hi_hold_q;
        high_time_d  = high_time_q;
        period_d     = period_q;
        saturated_d  = saturated_q;
        meas_valid_d = meas_valid_q;
        overrun_d    = overrun_q;
        edge_count_d = edge_count_q;
        rec_done     = 1'b0;

        if (rise_ok) begin
            edge_count_d = edge_count_q + CNT_ONE;
        end

        if (!enable) begin
            state_d = S_IDLE;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (rise_ok) begin
                        state_d   = S_HIGH;
                        hi_cnt_d  = CNT_ONE;
                        per_cnt_d = CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (rise_ok) begin
                        hi_cnt_d  = CNT_ONE;
                        per_cnt_d = CNT_ONE;
                    end else begin
                        hi_cnt_d  = sat_inc(hi_cnt_q);
                        per_cnt_d = sat_inc(per_cnt_q);
                        if (fall_ok) begin
                            state_d   = S_LOW;
                            hi_hold_d = hi_cnt_q;
                        end
                    end
                end
                S_LOW: begin
                    if (rise_ok) begin
                        rec_done  = 1'b1;
                        state_d   = S_HIGH;
                        hi_cnt_d  = CNT_ONE;
                        per_cnt_d = CNT_ONE;
                    end else begin
                        per_cnt_d = sat_inc(per_cnt_q);
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        if (xfer) begin
            meas_valid_d = 1'b0;
        end
        // A new record may replace one that is leaving this cycle; otherwise it is dropped.
        if (rec_done) begin
            if (!meas_valid_q || xfer) begin
                high_time_d  = hi_hold_q;
                period_d     = per_cnt_q;
                saturated_d  = (hi_hold_q == CNT_MAX) || (per_cnt_q == CNT_MAX);
                meas_valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end

        if (clear) begin
            state_d      = S_IDLE;
            hi_cnt_d     = '0;
            per_cnt_d    = '0;
            hi_hold_d    = '0;
            high_time_d  = '0;
            period_d     = '0;
            saturated_d  = 1'b0;
            meas_valid_d = 1'b0;
            overrun_d    = 1'b0;
            edge_count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            hi_cnt_q     <= '0;
            per_cnt_q    <= '0;
            hi_hold_q    <= '0;
            high_time_q  <= '0;
            period_q     <= '0;
            saturated_q  <= 1'b0;
            meas_valid_q <= 1'b0;
            overrun_q    <= 1'b0;
            edge_count_q <= '0;
        end else begin
            state_q      <= state_d;
            hi_cnt_q     <= hi_cnt_d;
            per_cnt_q    <= per_cnt_d;
            hi_hold_q    <= hi_hold_d;
            high_time_q  <= high_time_d;
            period_q     <= period_d;
            saturated_q  <= saturated_d;
            meas_valid_q <= meas_valid_d;
            overrun_q    <= overrun_d;
            edge_count_q <= edge_count_d;
        end
    end

    assign high_time  = high_time_q;
    assign period     = period_q;
    assign saturated  = saturated_q;
    assign meas_valid = meas_valid_q;
    assign overrun    = overrun_q;
    assign edge_count = edge_count_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Bench for pulse_width_meter at CNT_W=4 so saturation and edge-count wrap are reachable.
module tb_pulse_width_meter;

    localparam int CNT_W = 4;
    localparam int REC_W = 2 * CNT_W + 1;
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_HIGH = 2'd1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             enable = 1'b0;
    logic             clear = 1'b0;
    logic             rising_edge = 1'b0;
    logic             falling_edge = 1'b0;
    logic             meas_ready = 1'b0;
    logic [CNT_W-1:0] high_time;
    logic [CNT_W-1:0] period;
    logic [CNT_W-1:0] edge_count;
    logic             saturated;
    logic             meas_valid;
    logic             overrun;
    logic [1:0]       state_dbg;

    int n_checks = 0;
    int n_errors = 0;

    logic [REC_W-1:0] exp_q[$];

    typedef struct {
        int fall_at;
        int rise_at;
        int exp_hi;
        int exp_per;
        int exp_sat;
    } vec_t;
    vec_t vecs[8];

    pulse_width_meter #(.CNT_W(CNT_W)) dut (
        .clk          (clk),
        .reset        (reset),
        .enable       (enable),
        .clear        (clear),
        .rising_edge  (rising_edge),
        .falling_edge (falling_edge),
        .high_time    (high_time),
        .period       (period),
        .saturated    (saturated),
        .meas_valid   (meas_valid),
        .meas_ready   (meas_ready),
        .overrun      (overrun),
        .edge_count   (edge_count),
        .state_dbg    (state_dbg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp_v);
        end
    endtask

    function automatic logic [REC_W-1:0] mk_rec(input int hi, input int per, input int sat);
        logic [CNT_W-1:0] h;
        logic [CNT_W-1:0] p;
        logic             s;
        h = hi[CNT_W-1:0];
        p = per[CNT_W-1:0];
        s = (sat != 0);
        return {s, h, p};
    endfunction

    // One clock cycle; transfers seen mid-cycle are popped from the expected queue.
    task automatic tick();
        logic [REC_W-1:0] got;
        logic [REC_W-1:0] exp_rec;
        @(negedge clk);
        if (meas_valid === 1'b1 && meas_ready === 1'b1) begin
            got = {saturated, high_time, period};
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_record: got %0h expected none", got);
            end else begin
                exp_rec = exp_q.pop_front();
                check("record", got, exp_rec);
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_clear();
        meas_ready = 1'b0;
        clear = 1'b1;
        exp_q.delete();
        tick();
        clear = 1'b0;
    endtask

    // Rise at relative cycle 0 (skipped when continuing), fall at fall_at, rise at rise_at.
    task automatic run_period(input int fall_at, input int rise_at, input bit first,
                              input bit push, input logic [REC_W-1:0] rec);
        for (int c = (first ? 0 : 1); c <= rise_at; c++) begin
            rising_edge  = (c == 0) || (c == rise_at);
            falling_edge = (c == fall_at);
            if (c == rise_at && push) exp_q.push_back(rec);
            tick();
        end
        rising_edge  = 1'b0;
        falling_edge = 1'b0;
    endtask

    initial begin
        vecs[0] = '{fall_at: 3,  rise_at: 10, exp_hi: 3,  exp_per: 10, exp_sat: 0};
        vecs[1] = '{fall_at: 1,  rise_at: 2,  exp_hi: 1,  exp_per: 2,  exp_sat: 0};
        vecs[2] = '{fall_at: 2,  rise_at: 6,  exp_hi: 2,  exp_per: 6,  exp_sat: 0};
        vecs[3] = '{fall_at: 7,  rise_at: 14, exp_hi: 7,  exp_per: 14, exp_sat: 0};
        vecs[4] = '{fall_at: 14, rise_at: 15, exp_hi: 14, exp_per: 15, exp_sat: 1};
        vecs[5] = '{fall_at: 15, rise_at: 16, exp_hi: 15, exp_per: 15, exp_sat: 1};
        vecs[6] = '{fall_at: 20, rise_at: 25, exp_hi: 15, exp_per: 15, exp_sat: 1};
        vecs[7] = '{fall_at: 1,  rise_at: 15, exp_hi: 1,  exp_per: 15, exp_sat: 1};

        // Reset
        reset  = 1'b0;
        enable = 1'b1;
        repeat (3) tick();
        check("rst_valid", meas_valid, 0);
        check("rst_overrun", overrun, 0);
        check("rst_edges", edge_count, 0);
        check("rst_fields", {saturated, high_time, period}, 0);
        check("rst_state", state_dbg, ST_IDLE);
        reset = 1'b1;
        tick();
        check("post_rst_valid", meas_valid, 0);
        check("post_rst_edges", edge_count, 0);

        // Single-period vectors with ready held high
        for (int i = 0; i < 8; i++) begin
            do_clear();
            meas_ready = 1'b1;
            run_period(vecs[i].fall_at, vecs[i].rise_at, 1'b1, 1'b1,
                       mk_rec(vecs[i].exp_hi, vecs[i].exp_per, vecs[i].exp_sat));
            check("vec_valid", meas_valid, 1);
            check("vec_high", high_time, vecs[i].exp_hi);
            check("vec_period", period, vecs[i].exp_per);
            check("vec_sat", saturated, vecs[i].exp_sat);
            tick();
            check("vec_valid_drop", meas_valid, 0);
            check("vec_edges", edge_count, 2);
        end

        // Backpressure and overrun
        do_clear();
        run_period(4, 8, 1'b1, 1'b1, mk_rec(4, 8, 0));
        check("bp_valid", meas_valid, 1);
        check("bp_high", high_time, 4);
        check("bp_period", period, 8);
        check("bp_no_overrun", overrun, 0);
        run_period(4, 8, 1'b0, 1'b0, '0);
        check("bp_overrun", overrun, 1);
        check("bp_hold_valid", meas_valid, 1);
        check("bp_hold_high", high_time, 4);
        check("bp_hold_period", period, 8);
        meas_ready = 1'b1;
        tick();
        check("bp_valid_drop", meas_valid, 0);
        check("bp_overrun_sticky", overrun, 1);

        // Clear while overrun and a pending record
        do_clear();
        run_period(4, 8, 1'b1, 1'b0, '0);
        run_period(4, 8, 1'b0, 1'b0, '0);
        check("cl_pre_overrun", overrun, 1);
        check("cl_pre_valid", meas_valid, 1);
        do_clear();
        check("cl_overrun", overrun, 0);
        check("cl_valid", meas_valid, 0);
        check("cl_fields", {saturated, high_time, period}, 0);
        check("cl_edges", edge_count, 0);
        check("cl_state", state_dbg, ST_IDLE);

        // Missed fall: rise@0, rise@5, fall@7, rise@12
        do_clear();
        meas_ready = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            rising_edge  = (c == 0) || (c == 5) || (c == 12);
            falling_edge = (c == 7);
            if (c == 12) exp_q.push_back(mk_rec(2, 7, 0));
            tick();
        end
        rising_edge  = 1'b0;
        falling_edge = 1'b0;
        check("mf_valid", meas_valid, 1);
        check("mf_high", high_time, 2);
        check("mf_period", period, 7);
        check("mf_edges", edge_count, 3);
        tick();
        check("mf_valid_drop", meas_valid, 0);

        // Reset in cycle 4 of a HIGH phase (last rise was at relative cycle 12 above)
        repeat (2) tick();
        check("mr_pre_state", state_dbg, ST_HIGH);
        check("mr_pre_edges", edge_count, 3);
        reset = 1'b0;
        #1;
        check("mr_edges", edge_count, 0);
        check("mr_fields", {saturated, high_time, period}, 0);
        check("mr_valid", meas_valid, 0);
        check("mr_state", state_dbg, ST_IDLE);
        tick();
        reset = 1'b1;
        repeat (2) tick();
        run_period(2, 6, 1'b1, 1'b1, mk_rec(2, 6, 0));
        check("mr_rec_valid", meas_valid, 1);
        check("mr_rec_high", high_time, 2);
        check("mr_rec_period", period, 6);
        tick();
        check("mr_rec_edges", edge_count, 2);

        // Simultaneous pulses while HIGH are ignored
        do_clear();
        meas_ready = 1'b1;
        for (int c = 0; c <= 9; c++) begin
            rising_edge  = (c == 0) || (c == 2) || (c == 9);
            falling_edge = (c == 2) || (c == 5);
            if (c == 9) exp_q.push_back(mk_rec(5, 9, 0));
            tick();
        end
        rising_edge  = 1'b0;
        falling_edge = 1'b0;
        check("sim_valid", meas_valid, 1);
        check("sim_high", high_time, 5);
        check("sim_period", period, 9);
        check("sim_edges", edge_count, 2);
        tick();

        // Enable dropped during LOW
        do_clear();
        meas_ready = 1'b1;
        for (int c = 0; c <= 15; c++) begin
            if (c == 8) begin
                check("en_edges_frozen", edge_count, 1);
                check("en_state_idle", state_dbg, ST_IDLE);
                check("en_no_valid", meas_valid, 0);
            end
            enable       = !(c >= 5 && c <= 7);
            rising_edge  = (c == 0) || (c == 6) || (c == 10) || (c == 15);
            falling_edge = (c == 3) || (c == 12);
            if (c == 15) exp_q.push_back(mk_rec(2, 5, 0));
            tick();
        end
        rising_edge  = 1'b0;
        falling_edge = 1'b0;
        enable       = 1'b1;
        check("en_valid", meas_valid, 1);
        check("en_high", high_time, 2);
        check("en_period", period, 5);
        check("en_edges", edge_count, 3);
        tick();

        // Edge counter wraps modulo 2^CNT_W
        do_clear();
        meas_ready = 1'b1;
        for (int k = 0; k < 17; k++) begin
            rising_edge = 1'b1;
            tick();
            rising_edge = 1'b0;
            tick();
        end
        check("wrap_edges", edge_count, 17 % (1 << CNT_W));
        check("wrap_valid", meas_valid, 0);

        check("queue_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
